// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - priority layer mux, view border, fade attenuation; 2-cycle registered RGB pipeline
module layer_compositor #(
    parameter int                        LAYERS           = 4,
    parameter int                        COLOR_BITS       = 4,
    parameter int                        VIEW_LEFT_X      = 340,
    parameter int                        VIEW_RIGHT_X     = 682,
    parameter logic [3:0][LAYERS-1:0]    STATE_MASKS      = '1,
    parameter logic [3*COLOR_BITS-1:0]   BG_COLOR         = '1,
    parameter logic [3*COLOR_BITS-1:0]   BORDER_COLOR     = '0,
    parameter int                        FADE_STEP_FRAMES = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    draw_i,
    input  logic [10:0]                             beam_x_i,
    input  logic [9:0]                              beam_y_i,
    input  logic                                    frame_strobe_i,
    input  logic [1:0]                              game_state_i,
    input  logic [LAYERS-1:0][2:0][COLOR_BITS-1:0]  layer_color_i,
    input  logic [LAYERS-1:0]                       layer_transparency_i,
    input  logic                                    fade_request_i,
    output logic [COLOR_BITS-1:0]                   red_o,
    output logic [COLOR_BITS-1:0]                   green_o,
    output logic [COLOR_BITS-1:0]                   blue_o,
    output logic                                    draw_out_o,
    output logic [COLOR_BITS-1:0]                   fade_level_o,
    output logic                                    fade_busy_o,
    output logic                                    fade_done_o
);

    localparam int PIX_W  = 3 * COLOR_BITS;
    localparam int STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [COLOR_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [COLOR_BITS-1:0] LEVEL_ONE = COLOR_BITS'(1);

    localparam logic [1:0] SHOW     = 2'd0;
    localparam logic [1:0] FADE_OUT = 2'd1;
    localparam logic [1:0] DARK     = 2'd2;
    localparam logic [1:0] FADE_IN  = 2'd3;

    logic                  unused_beam_y;
    assign unused_beam_y = ^beam_y_i;

    logic [PIX_W-1:0]      s1_pix_q, s1_pix_d;
    logic                  s1_draw_q;
    logic [PIX_W-1:0]      out_q, out_d;
    logic                  draw_out_q;
    logic [1:0]            state_q, state_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [COLOR_BITS-1:0] level_q, level_d;
    logic                  done_q, done_d;
    logic [LAYERS-1:0]     enabled;
    logic                  outside_view;

    // Stage 1: lowest-index enabled opaque layer wins; border overrides everything
    always_comb begin
        enabled      = STATE_MASKS[game_state_i] & ~layer_transparency_i;
        outside_view = (beam_x_i < 11'(VIEW_LEFT_X)) || (beam_x_i >= 11'(VIEW_RIGHT_X));
        s1_pix_d     = BG_COLOR;
        for (int l = LAYERS - 1; l >= 0; l--) begin
            if (enabled[l]) begin
                s1_pix_d = layer_color_i[l];
            end
        end
        if (outside_view) begin
            s1_pix_d = BORDER_COLOR;
        end
    end

    // Stage 2: saturating subtract of the fade level from each channel
    logic [2:0][COLOR_BITS:0] diff;
    always_comb begin
        diff  = '0;
        out_d = '0;
        for (int c = 0; c < 3; c++) begin
            diff[c] = {1'b0, s1_pix_q[c*COLOR_BITS +: COLOR_BITS]} - {1'b0, level_q};
            out_d[c*COLOR_BITS +: COLOR_BITS] = diff[c][COLOR_BITS] ? '0 : diff[c][COLOR_BITS-1:0];
        end
        if (!s1_draw_q) begin
            out_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        level_d = level_q;
        done_d  = 1'b0;
        case (state_q)
            SHOW: begin
                level_d = '0;
                if (fade_request_i) begin
                    state_d = FADE_OUT;
                    step_d  = '0;
                end
            end
            FADE_OUT: begin
                if (frame_strobe_i) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q + LEVEL_ONE;
                        if (level_q == LEVEL_MAX - LEVEL_ONE) begin
                            state_d = DARK;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            DARK: begin
                level_d = LEVEL_MAX;
                if (fade_request_i) begin
                    state_d = FADE_IN;
                    step_d  = '0;
                end
            end
            FADE_IN: begin
                if (frame_strobe_i) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q - LEVEL_ONE;
                        if (level_q == LEVEL_ONE) begin
                            state_d = SHOW;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: state_d = SHOW;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_pix_q   <= '0;
            s1_draw_q  <= 1'b0;
            out_q      <= '0;
            draw_out_q <= 1'b0;
            state_q    <= SHOW;
            step_q     <= '0;
            level_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            s1_pix_q   <= s1_pix_d;
            s1_draw_q  <= draw_i;
            out_q      <= out_d;
            draw_out_q <= s1_draw_q;
            state_q    <= state_d;
            step_q     <= step_d;
            level_q    <= level_d;
            done_q     <= done_d;
        end
    end

    assign red_o        = out_q[2*COLOR_BITS +: COLOR_BITS];
    assign green_o      = out_q[COLOR_BITS +: COLOR_BITS];
    assign blue_o       = out_q[0 +: COLOR_BITS];
    assign draw_out_o   = draw_out_q;
    assign fade_level_o = level_q;
    assign fade_busy_o  = (state_q == FADE_OUT) || (state_q == FADE_IN);
    assign fade_done_o  = done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed and randomized checks of layer_compositor against a behavioural model
module tb_layer_compositor;

    localparam int          FSF   = 2;
    localparam logic [15:0] MASKS = {4'b0101, 4'b0011, 4'b0010, 4'b1111};

    logic             clk = 1'b0;
    logic             rst;
    logic             draw;
    logic [10:0]      beam_x;
    logic [9:0]       beam_y;
    logic             strobe;
    logic [1:0]       gs;
    logic [3:0][11:0] lcol;
    logic [3:0]       lt;
    logic             req;
    logic [3:0]       red, green, blue, fade_level;
    logic             draw_out, fade_busy, fade_done;

    int n_chk = 0;
    int n_err = 0;

    // Model: fade expressed as strobes counted since the fade began
    int         m_mode;
    int         m_strobes;
    int         m_level;
    bit         m_done;
    logic [12:0] m_pend;
    logic [12:0] m_out;

    always #5 clk = ~clk;

    layer_compositor #(
        .FADE_STEP_FRAMES(FSF),
        .STATE_MASKS     (MASKS)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .draw_i              (draw),
        .beam_x_i            (beam_x),
        .beam_y_i            (beam_y),
        .frame_strobe_i      (strobe),
        .game_state_i        (gs),
        .layer_color_i       (lcol),
        .layer_transparency_i(lt),
        .fade_request_i      (req),
        .red_o               (red),
        .green_o             (green),
        .blue_o              (blue),
        .draw_out_o          (draw_out),
        .fade_level_o        (fade_level),
        .fade_busy_o         (fade_busy),
        .fade_done_o         (fade_done)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_pix(input int x, input int g, input logic [3:0][11:0] c,
                                            input logic [3:0] t);
        if (x < 340 || x >= 682) return 12'h000;
        for (int l = 0; l < 4; l++) begin
            if (MASKS[g*4+l] && !t[l]) return c[l];
        end
        return 12'hFFF;
    endfunction

    function automatic logic [11:0] atten(input logic [11:0] p, input int lvl);
        int r = 0;
        for (int c = 0; c < 3; c++) begin
            int ch = (int'(p) >> (4*c)) & 15;
            ch = (ch > lvl) ? ch - lvl : 0;
            r = r | (ch << (4*c));
        end
        return 12'(r);
    endfunction

    task automatic tick();
        int old_level = m_level;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_strobes = 0; m_level = 0; m_done = 0;
            m_pend = '0; m_out = '0;
        end else begin
            m_out  = m_pend[12] ? {1'b1, atten(m_pend[11:0], old_level)} : 13'h0;
            m_pend = {draw, ref_pix(int'(beam_x), int'(gs), lcol, lt)};
            m_done = 0;
            if ((m_mode == 0 || m_mode == 2) && req) begin
                m_mode    = m_mode + 1;
                m_strobes = 0;
            end else if ((m_mode == 1 || m_mode == 3) && strobe) begin
                m_strobes++;
                if (m_strobes / FSF >= 15) begin
                    m_mode = (m_mode + 1) % 4;
                    m_done = 1;
                end
            end
            if (m_mode == 1)      m_level = m_strobes / FSF;
            else if (m_mode == 3) m_level = 15 - m_strobes / FSF;
            else if (m_mode == 2) m_level = 15;
            else                  m_level = 0;
        end
        #1;
        chk_eq("rgb", {red, green, blue}, m_out[11:0]);
        chk_eq("draw_out", draw_out, m_out[12]);
        chk_eq("fade_level", fade_level, m_level);
        chk_eq("fade_busy", fade_busy, (m_mode == 1 || m_mode == 3));
        chk_eq("fade_done", fade_done, m_done);
    endtask

    initial begin
        int dcount;
        rst = 1; draw = 0; beam_x = 0; beam_y = 0; strobe = 0; gs = 0;
        lcol = '0; lt = '1; req = 0;
        m_mode = 0; m_strobes = 0; m_level = 0; m_done = 0; m_pend = '0; m_out = '0;
        tick(); tick();
        chk_eq("rst_rgb", {red, green, blue}, 12'h000);
        chk_eq("rst_level", fade_level, 0);
        chk_eq("rst_busy", fade_busy, 0);
        rst = 0;

        lcol[1] = 12'hF00; lcol[0] = 12'h0F0; lt = 4'b1101; beam_x = 400; draw = 1;
        tick(); tick();
        chk_eq("layer1_red", {red, green, blue}, 12'hF00);
        chk_eq("layer1_draw", draw_out, 1);

        lt = 4'b0000; gs = 1;
        tick(); tick();
        chk_eq("mask_0010", {red, green, blue}, 12'hF00);
        gs = 2;
        tick(); tick();
        chk_eq("mask_0011", {red, green, blue}, 12'h0F0);

        gs = 0; beam_x = 339;
        tick(); tick();
        chk_eq("border_339", {red, green, blue}, 12'h000);
        beam_x = 682;
        tick(); tick();
        chk_eq("border_682", {red, green, blue}, 12'h000);
        beam_x = 340;
        tick(); tick();
        chk_eq("view_340", {red, green, blue}, 12'h0F0);
        beam_x = 500; lt = 4'hF;
        tick(); tick();
        chk_eq("bg_500", {red, green, blue}, 12'hFFF);

        draw = 0; beam_x = 400; lt = 4'h0;
        tick(); tick();
        chk_eq("nodraw_rgb", {red, green, blue}, 12'h000);
        chk_eq("nodraw_flag", draw_out, 0);

        draw = 1; lt = 4'b1110; req = 1;
        tick();
        req = 0;
        chk_eq("fade_start_busy", fade_busy, 1);
        dcount = 0;
        for (int i = 1; i <= 30; i++) begin
            strobe = 1;
            req = (i == 5);
            tick();
            strobe = 0; req = 0;
            if (fade_done) dcount++;
            chk_eq("fade_step", fade_level, i / FSF);
            if (i == 12) lcol[0] = 12'hA5F;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (fade_done) dcount++;
                if (i == 12 && k == 1) chk_eq("atten_a5f", {red, green, blue}, 12'h409);
            end
            lcol[0] = 12'h0F0;
        end
        chk_eq("done_once", dcount, 1);
        chk_eq("dark_level", fade_level, 15);
        chk_eq("dark_busy", fade_busy, 0);

        req = 1;
        tick();
        req = 0;
        for (int i = 1; i <= 16; i++) begin
            strobe = 1; tick(); strobe = 0; tick();
        end
        chk_eq("fadein_level7", fade_level, 7);
        rst = 1;
        tick();
        rst = 0;
        chk_eq("rst_fade_level", fade_level, 0);
        chk_eq("rst_fade_busy", fade_busy, 0);
        chk_eq("rst_fade_rgb", {red, green, blue}, 12'h000);
        chk_eq("rst_fade_draw", draw_out, 0);

        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 5))
                0:       beam_x = 11'($urandom_range(338, 342));
                1:       beam_x = 11'($urandom_range(680, 684));
                default: beam_x = 11'($urandom_range(300, 720));
            endcase
            beam_y = 10'($urandom_range(0, 479));
            for (int l = 0; l < 4; l++) lcol[l] = 12'($urandom);
            lt     = 4'($urandom);
            gs     = 2'($urandom);
            draw   = ($urandom_range(0, 7) != 0);
            strobe = ($urandom_range(0, 7) == 0);
            req    = ($urandom_range(0, 39) == 0);
            rst    = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
